// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: ALU opcodes, datapath widths and ID/EX control bundle.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic                  valid;
    logic                  RegWEn;
    logic                  ASel;
    logic                  BSel;
    alu_op_t               ALUSel;
    logic [REG_ADDR_W-1:0] rd_addr;
  } idex_ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB, x0 is never forwarded.
module fwd_mux #(
  parameter int nbit = 32,
  parameter int rbit = 5
) (
  input  logic [rbit-1:0] rs_addr,
  input  logic [nbit-1:0] rs_data,
  input  logic            exm_valid,
  input  logic            exm_RegWEn,
  input  logic [rbit-1:0] exm_rd_addr,
  input  logic [nbit-1:0] exm_result,
  input  logic            wb_valid,
  input  logic            wb_RegWEn,
  input  logic [rbit-1:0] wb_rd_addr,
  input  logic [nbit-1:0] wb_data,
  output logic [nbit-1:0] fwd_data
);

  logic rs_nonzero;
  logic exm_hit;
  logic wb_hit;

  assign rs_nonzero = (rs_addr != '0);
  assign exm_hit    = exm_valid & exm_RegWEn & (exm_rd_addr == rs_addr) & rs_nonzero;
  assign wb_hit     = wb_valid & wb_RegWEn & (wb_rd_addr == rs_addr) & rs_nonzero;

  always_comb begin
    fwd_data = rs_data;
    if (exm_hit) begin
      fwd_data = exm_result;
    end else if (wb_hit) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB; feeds the ALU.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int nbit = 32,
  parameter int rbit = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [nbit-1:0] id_pc,
  input  logic [nbit-1:0] id_rs1_data,
  input  logic [nbit-1:0] id_rs2_data,
  input  logic [nbit-1:0] id_imm,
  input  logic [rbit-1:0] id_rs1_addr,
  input  logic [rbit-1:0] id_rs2_addr,
  input  logic [rbit-1:0] id_rd_addr,
  input  alu_op_t         id_ALUSel,
  input  logic            id_ASel,
  input  logic            id_BSel,
  input  logic            id_RegWEn,
  input  logic            exm_valid,
  input  logic            exm_RegWEn,
  input  logic [rbit-1:0] exm_rd_addr,
  input  logic [nbit-1:0] exm_result,
  input  logic            wb_valid,
  input  logic            wb_RegWEn,
  input  logic [rbit-1:0] wb_rd_addr,
  input  logic [nbit-1:0] wb_data,
  output logic [nbit-1:0] in1,
  output logic [nbit-1:0] in2,
  output alu_op_t         ALUSel,
  output logic            ex_valid,
  output logic [nbit-1:0] ex_pc,
  output logic [nbit-1:0] ex_rs2_fwd,
  output logic [rbit-1:0] ex_rd_addr,
  output logic            ex_RegWEn
);

  idex_ctrl_t      ctrl_q;
  logic [nbit-1:0] pc_q;
  logic [nbit-1:0] imm_q;
  logic [nbit-1:0] rs1_data_q;
  logic [nbit-1:0] rs2_data_q;
  logic [rbit-1:0] rs1_addr_q;
  logic [rbit-1:0] rs2_addr_q;
  logic [nbit-1:0] fwd_rs1;
  logic [nbit-1:0] fwd_rs2;

  // Flush beats stall; a stall refreshes operand values from the forwarding
  // network so a producer retiring mid-stall is not lost once it leaves WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
    end else if (flush) begin
      ctrl_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
    end else if (stall) begin
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else begin
      ctrl_q.valid   <= id_valid;
      ctrl_q.RegWEn  <= id_RegWEn & id_valid;
      ctrl_q.ASel    <= id_ASel;
      ctrl_q.BSel    <= id_BSel;
      ctrl_q.ALUSel  <= id_ALUSel;
      ctrl_q.rd_addr <= id_rd_addr;
      pc_q           <= id_pc;
      imm_q          <= id_imm;
      rs1_data_q     <= id_rs1_data;
      rs2_data_q     <= id_rs2_data;
      rs1_addr_q     <= id_rs1_addr;
      rs2_addr_q     <= id_rs2_addr;
    end
  end

  fwd_mux #(.nbit(nbit), .rbit(rbit)) u_fwd_rs1 (
    .rs_addr     (rs1_addr_q),
    .rs_data     (rs1_data_q),
    .exm_valid   (exm_valid),
    .exm_RegWEn  (exm_RegWEn),
    .exm_rd_addr (exm_rd_addr),
    .exm_result  (exm_result),
    .wb_valid    (wb_valid),
    .wb_RegWEn   (wb_RegWEn),
    .wb_rd_addr  (wb_rd_addr),
    .wb_data     (wb_data),
    .fwd_data    (fwd_rs1)
  );

  fwd_mux #(.nbit(nbit), .rbit(rbit)) u_fwd_rs2 (
    .rs_addr     (rs2_addr_q),
    .rs_data     (rs2_data_q),
    .exm_valid   (exm_valid),
    .exm_RegWEn  (exm_RegWEn),
    .exm_rd_addr (exm_rd_addr),
    .exm_result  (exm_result),
    .wb_valid    (wb_valid),
    .wb_RegWEn   (wb_RegWEn),
    .wb_rd_addr  (wb_rd_addr),
    .wb_data     (wb_data),
    .fwd_data    (fwd_rs2)
  );

  assign in1        = ctrl_q.ASel ? pc_q : fwd_rs1;
  assign in2        = ctrl_q.BSel ? imm_q : fwd_rs2;
  assign ex_rs2_fwd = fwd_rs2;
  assign ALUSel     = ctrl_q.ALUSel;
  assign ex_valid   = ctrl_q.valid;
  assign ex_RegWEn  = ctrl_q.RegWEn;
  assign ex_rd_addr = ctrl_q.rd_addr;
  assign ex_pc      = pc_q;

endmodule
